decode_stage_pipe: RTL and testbench
====================================

DECODE_STAGE_PIPE -- requirements
Module: decode_stage_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width of register data, PC and immediate.
REQ-002 Parameter NREG, default 32, number of architectural registers; AW = clog2(NREG).
REQ-003 Parameter CTRL_W, default 24, width of the opaque pre-decoded control bundle.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 valid_d  in  1  decode-stage instruction valid.
REQ-007 instr_d  in  32  decode-stage instruction; rs1=[19:15], rs2=[24:20], rd=[11:7], funct3=[14:12], low AW bits used.
REQ-008 pc_d, pc4_d  in  XLEN each  PC and PC+4 of instr_d.
REQ-009 ctrl_d  in  CTRL_W  decoded control bundle; imm_d  in  XLEN  extended immediate; ld_d  in  1  instr_d is a load.
REQ-010 stall_e  in  1  downstream hold request; flush_e  in  1  branch/jump redirect kill.
REQ-011 regwrite_w  in  1, rd_w  in  AW, result_w  in  XLEN  write-back port.
REQ-012 valid_e, ld_e  out  1; ctrl_e  out  CTRL_W; rd1_e, rd2_e, imm_e, pc_e, pc4_e  out  XLEN; rs1_e, rs2_e, rd_e  out  AW; funct3_e  out  3  registered ID/EX outputs.
REQ-013 stall_d  out  1  combinational request to hold the PC and IF/ID registers.

Function
REQ-014 The register file SHALL hold NREG x XLEN entries, with register 0 always reading zero and never written.
REQ-015 A write SHALL occur on the clock edge when regwrite_w=1 and rd_w!=0, regardless of stall, flush or bubble.
REQ-016 Each read port SHALL return result_w when regwrite_w=1, rd_w!=0 and rd_w equals the read address (same-cycle write-through); otherwise it SHALL return the stored value.
REQ-017 hazard = valid_d & valid_e & ld_e & rd_e!=0 & (rd_e==rs1_d | rd_e==rs2_d), evaluated on the low AW bits.
REQ-018 stall_d = ~flush_e & (stall_e | hazard).
REQ-019 Per edge, ID/EX update priority SHALL be: flush_e, then stall_e, then hazard, then normal load.
REQ-020 On flush_e: valid_e, ld_e and ctrl_e SHALL be set to 0 and rd_e SHALL be set to 0; the other fields are don't-care.
REQ-021 On stall_e without flush_e: all ID/EX registers SHALL hold their values.
REQ-022 On hazard without stall_e or flush_e, a bubble SHALL be inserted: valid_e, ld_e, ctrl_e and rd_e SHALL be 0, and the remaining fields SHALL load normally.
REQ-023 On normal load: valid_e <= valid_d, and all fields SHALL load from decode inputs and register-file reads.
REQ-024 On normal load with valid_d=0: ctrl_e, ld_e and rd_e SHALL be 0.
REQ-025 Latency SHALL be one cycle from decode inputs to E outputs; the load-use bubble costs exactly one cycle.
REQ-026 A held (stall_e) entry SHALL not re-read the register file, so its rd1_e and rd2_e stay frozen.

Reset
REQ-027 While rst=0: every ID/EX output SHALL be 0, and all register-file entries SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL clear state immediately, without waiting for a clock edge.
REQ-029 Reset SHALL take priority over any write-back or load occurring in the same cycle.
REQ-030 First load SHALL occur on the first rising edge after rst deasserts.

Verification
REQ-031 Bypass: regwrite_w=1, rd_w=5, result_w=0xDEADBEEF while rs1_d=5 -> rd1_e=0xDEADBEEF on the next edge.
REQ-032 x0: write 0x1234 to rd_w=0, then read rs2_d=0 -> rd2_e=0.
REQ-033 Load-use: load with rd=7 in E, decode rs2=7 valid -> stall_d=1 for one cycle, bubble (valid_e=0, ctrl_e=0), then instruction issues with valid_e=1.
REQ-034 Concurrent events: stall_e=1 and hazard=1 -> stall_d=1 and E is held unchanged; flush_e=1 with stall_e=1 -> stall_d=0 and valid_e=0.
REQ-035 Reset mid-stream: rst=0 between edges -> all outputs 0 immediately, and a later read of register 10 returns 0.
REQ-036 Parameter sweep: XLEN=64, NREG=16 -> 64-bit values 0xFFFF_0000_0000_0001 pass unchanged, and rd index 4 bits wide.

Source files
------------

// File: rtl/decode_stage_pipe.sv
// Decode stage: register file with write-through reads, load-use hazard
// detection and the ID/EX pipeline register with flush/stall/bubble control.
module decode_stage_pipe #(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int CTRL_W = 24,
   localparam int AW    = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_d,
   input  logic [31:0]       instr_d,
   input  logic [XLEN-1:0]   pc_d,
   input  logic [XLEN-1:0]   pc4_d,
   input  logic [CTRL_W-1:0] ctrl_d,
   input  logic [XLEN-1:0]   imm_d,
   input  logic              ld_d,
   input  logic              stall_e,
   input  logic              flush_e,
   input  logic              regwrite_w,
   input  logic [AW-1:0]     rd_w,
   input  logic [XLEN-1:0]   result_w,
   output logic              valid_e,
   output logic              ld_e,
   output logic [CTRL_W-1:0] ctrl_e,
   output logic [XLEN-1:0]   rd1_e,
   output logic [XLEN-1:0]   rd2_e,
   output logic [XLEN-1:0]   imm_e,
   output logic [XLEN-1:0]   pc_e,
   output logic [XLEN-1:0]   pc4_e,
   output logic [AW-1:0]     rs1_e,
   output logic [AW-1:0]     rs2_e,
   output logic [AW-1:0]     rd_e,
   output logic [2:0]        funct3_e,
   output logic              stall_d
);

   logic [XLEN-1:0] rf [NREG];
   logic [AW-1:0]   rs1_d, rs2_d, rd_d;
   logic [XLEN-1:0] rd1_d, rd2_d;
   logic            write_en, hazard, issue;
   logic            unused_instr;

   assign rs1_d = instr_d[15 +: AW];
   assign rs2_d = instr_d[20 +: AW];
   assign rd_d  = instr_d[7 +: AW];
   // Opcode/funct7 bits are decoded upstream into ctrl_d.
   assign unused_instr = ^instr_d;

   assign write_en = regwrite_w && (rd_w != '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NREG; i++) rf[i] <= '0;
      end else if (write_en) begin
         rf[rd_w] <= result_w;
      end
   end

   // Same-cycle write-through so the reader never sees a stale value.
   always_comb begin
      rd1_d = rf[rs1_d];
      rd2_d = rf[rs2_d];
      if (write_en && rd_w == rs1_d) rd1_d = result_w;
      if (write_en && rd_w == rs2_d) rd2_d = result_w;
   end

   assign hazard = valid_d && valid_e && ld_e && (rd_e != '0)
                   && ((rd_e == rs1_d) || (rd_e == rs2_d));
   assign stall_d = !flush_e && (stall_e || hazard);
   assign issue   = valid_d && !hazard;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_e  <= 1'b0;
         ld_e     <= 1'b0;
         ctrl_e   <= '0;
         rd1_e    <= '0;
         rd2_e    <= '0;
         imm_e    <= '0;
         pc_e     <= '0;
         pc4_e    <= '0;
         rs1_e    <= '0;
         rs2_e    <= '0;
         rd_e     <= '0;
         funct3_e <= '0;
      end else if (flush_e) begin
         valid_e <= 1'b0;
         ld_e    <= 1'b0;
         ctrl_e  <= '0;
         rd_e    <= '0;
      end else if (!stall_e) begin
         // A bubble and an invalid decode slot share the same squashing.
         valid_e  <= issue;
         ld_e     <= issue && ld_d;
         ctrl_e   <= issue ? ctrl_d : '0;
         rd_e     <= issue ? rd_d : '0;
         rd1_e    <= rd1_d;
         rd2_e    <= rd2_d;
         imm_e    <= imm_d;
         pc_e     <= pc_d;
         pc4_e    <= pc4_d;
         rs1_e    <= rs1_d;
         rs2_e    <= rs2_d;
         funct3_e <= instr_d[14:12];
      end
   end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: directed vector table, reset corner cases,
// randomized traffic against a reference model, and a 64-bit/16-reg instance.
module tb_decode_stage_pipe;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        valid_d, ld_d, stall_e, flush_e, regwrite_w;
   logic [31:0] instr_d, pc_d, pc4_d, imm_d, result_w;
   logic [23:0] ctrl_d;
   logic [4:0]  rd_w;
   logic        valid_e, ld_e, stall_d;
   logic [23:0] ctrl_e;
   logic [31:0] rd1_e, rd2_e, imm_e, pc_e, pc4_e;
   logic [4:0]  rs1_e, rs2_e, rd_e;
   logic [2:0]  funct3_e;

   decode_stage_pipe dut (
      .clk(clk), .rst(rst), .valid_d(valid_d), .instr_d(instr_d),
      .pc_d(pc_d), .pc4_d(pc4_d), .ctrl_d(ctrl_d), .imm_d(imm_d), .ld_d(ld_d),
      .stall_e(stall_e), .flush_e(flush_e), .regwrite_w(regwrite_w),
      .rd_w(rd_w), .result_w(result_w), .valid_e(valid_e), .ld_e(ld_e),
      .ctrl_e(ctrl_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e),
      .pc_e(pc_e), .pc4_e(pc4_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
      .funct3_e(funct3_e), .stall_d(stall_d)
   );

   logic        q_valid_d, q_ld_d, q_stall_e, q_flush_e, q_rw;
   logic [31:0] q_instr_d;
   logic [63:0] q_pc_d, q_pc4_d, q_imm_d, q_res;
   logic [23:0] q_ctrl_d;
   logic [3:0]  q_rdw;
   logic        q_valid_e, q_ld_e, q_stall_d;
   logic [23:0] q_ctrl_e;
   logic [63:0] q_rd1_e, q_rd2_e, q_imm_e, q_pc_e, q_pc4_e;
   logic [3:0]  q_rs1_e, q_rs2_e, q_rd_e;
   logic [2:0]  q_f3_e;

   decode_stage_pipe #(.XLEN(64), .NREG(16), .CTRL_W(24)) dut64 (
      .clk(clk), .rst(rst), .valid_d(q_valid_d), .instr_d(q_instr_d),
      .pc_d(q_pc_d), .pc4_d(q_pc4_d), .ctrl_d(q_ctrl_d), .imm_d(q_imm_d),
      .ld_d(q_ld_d), .stall_e(q_stall_e), .flush_e(q_flush_e),
      .regwrite_w(q_rw), .rd_w(q_rdw), .result_w(q_res),
      .valid_e(q_valid_e), .ld_e(q_ld_e), .ctrl_e(q_ctrl_e),
      .rd1_e(q_rd1_e), .rd2_e(q_rd2_e), .imm_e(q_imm_e), .pc_e(q_pc_e),
      .pc4_e(q_pc4_e), .rs1_e(q_rs1_e), .rs2_e(q_rs2_e), .rd_e(q_rd_e),
      .funct3_e(q_f3_e), .stall_d(q_stall_d)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [2:0] f3);
      return {7'h00, rs2, rs1, f3, rd, 7'h03};
   endfunction

   // Reference model: architectural register array plus the E-stage contents.
   typedef struct packed {
      logic        v;
      logic        ld;
      logic [23:0] ctrl;
      logic [31:0] rd1, rd2, imm, pc, pc4;
      logic [4:0]  rs1, rs2, rd;
      logic [2:0]  f3;
   } e_t;

   e_t          m;
   logic        m_dc;
   logic [31:0] mrf [32];

   task automatic model_reset();
      m = '0;
      m_dc = 1'b0;
      for (int i = 0; i < 32; i++) mrf[i] = '0;
   endtask

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (regwrite_w && rd_w != 5'd0 && rd_w == a) return result_w;
      return mrf[a];
   endfunction

   function automatic logic m_hazard();
      logic [4:0] a, b;
      a = instr_d[19:15];
      b = instr_d[24:20];
      return valid_d && m.v && m.ld && m.rd != 5'd0 && (m.rd == a || m.rd == b);
   endfunction

   task automatic model_edge();
      e_t   n;
      logic go;
      n  = m;
      go = valid_d && !m_hazard();
      if (flush_e) begin
         n.v = 1'b0; n.ld = 1'b0; n.ctrl = '0; n.rd = '0;
         m_dc = 1'b1;
      end else if (!stall_e) begin
         n.v    = go;
         n.ld   = go && ld_d;
         n.ctrl = go ? ctrl_d : 24'h0;
         n.rd   = go ? instr_d[11:7] : 5'h0;
         n.rd1  = m_read(instr_d[19:15]);
         n.rd2  = m_read(instr_d[24:20]);
         n.imm  = imm_d;
         n.pc   = pc_d;
         n.pc4  = pc4_d;
         n.rs1  = instr_d[19:15];
         n.rs2  = instr_d[24:20];
         n.f3   = instr_d[14:12];
         m_dc   = 1'b0;
      end
      if (regwrite_w && rd_w != 5'd0) mrf[rd_w] = result_w;
      m = n;
   endtask

   task automatic check_model();
      chk("valid_e", 64'(valid_e), 64'(m.v));
      chk("ld_e",    64'(ld_e),    64'(m.ld));
      chk("ctrl_e",  64'(ctrl_e),  64'(m.ctrl));
      chk("rd_e",    64'(rd_e),    64'(m.rd));
      if (!m_dc) begin
         chk("rd1_e",    64'(rd1_e),    64'(m.rd1));
         chk("rd2_e",    64'(rd2_e),    64'(m.rd2));
         chk("imm_e",    64'(imm_e),    64'(m.imm));
         chk("pc_e",     64'(pc_e),     64'(m.pc));
         chk("pc4_e",    64'(pc4_e),    64'(m.pc4));
         chk("rs1_e",    64'(rs1_e),    64'(m.rs1));
         chk("rs2_e",    64'(rs2_e),    64'(m.rs2));
         chk("funct3_e", 64'(funct3_e), 64'(m.f3));
      end
   endtask

   task automatic step_model();
      chk("stall_d", 64'(stall_d), 64'(!flush_e && (stall_e || m_hazard())));
      model_edge();
      @(posedge clk);
      #1;
      check_model();
   endtask

   task automatic cycle();
      #2;
      step_model();
   endtask

   task automatic idle();
      valid_d = 0; ld_d = 0; stall_e = 0; flush_e = 0; regwrite_w = 0;
      instr_d = '0; pc_d = '0; pc4_d = '0; imm_d = '0; result_w = '0;
      ctrl_d = '0; rd_w = '0;
   endtask

   typedef struct {
      logic        rw;
      logic [4:0]  rdw;
      logic [31:0] res;
      logic        vd, ld;
      logic [4:0]  rd, rs1, rs2;
      logic [23:0] ctrl;
      logic        st, fl;
      logic        x_stall, x_valid;
      logic [23:0] x_ctrl;
      logic        x_data;
      logic [31:0] x_rd1, x_rd2;
   } vec_t;

   vec_t tv [10];

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      // rw rdw res | vd ld rd rs1 rs2 ctrl | st fl | x_stall x_valid x_ctrl x_data x_rd1 x_rd2
      tv[0] = '{1, 5'd5, 32'hDEADBEEF, 1, 0, 5'd1, 5'd5, 5'd0, 24'h1, 0, 0, 0, 1, 24'h1, 1, 32'hDEADBEEF, 32'h0};
      tv[1] = '{1, 5'd0, 32'h00001234, 1, 0, 5'd2, 5'd5, 5'd0, 24'h2, 0, 0, 0, 1, 24'h2, 1, 32'hDEADBEEF, 32'h0};
      tv[2] = '{0, 5'd0, 32'h0,        1, 0, 5'd3, 5'd0, 5'd0, 24'h3, 0, 0, 0, 1, 24'h3, 1, 32'h0, 32'h0};
      tv[3] = '{1, 5'd7, 32'h00000077, 1, 1, 5'd7, 5'd5, 5'd5, 24'h4, 0, 0, 0, 1, 24'h4, 1, 32'hDEADBEEF, 32'hDEADBEEF};
      tv[4] = '{0, 5'd0, 32'h0,        1, 0, 5'd3, 5'd1, 5'd7, 24'h5, 0, 0, 1, 0, 24'h0, 1, 32'h0, 32'h77};
      tv[5] = '{0, 5'd0, 32'h0,        1, 0, 5'd3, 5'd1, 5'd7, 24'h5, 0, 0, 0, 1, 24'h5, 1, 32'h0, 32'h77};
      tv[6] = '{0, 5'd0, 32'h0,        1, 1, 5'd9, 5'd0, 5'd0, 24'hA, 0, 0, 0, 1, 24'hA, 1, 32'h0, 32'h0};
      tv[7] = '{0, 5'd0, 32'h0,        1, 0, 5'd4, 5'd9, 5'd0, 24'hB, 1, 0, 1, 1, 24'hA, 1, 32'h0, 32'h0};
      tv[8] = '{0, 5'd0, 32'h0,        1, 0, 5'd4, 5'd9, 5'd0, 24'hB, 1, 1, 0, 0, 24'h0, 0, 32'h0, 32'h0};
      tv[9] = '{0, 5'd0, 32'h0,        0, 1, 5'd6, 5'd5, 5'd7, 24'hC, 0, 0, 0, 0, 24'h0, 1, 32'hDEADBEEF, 32'h77};

      idle();
      q_valid_d = 0; q_ld_d = 0; q_stall_e = 0; q_flush_e = 0; q_rw = 0;
      q_instr_d = '0; q_pc_d = '0; q_pc4_d = '0; q_imm_d = '0; q_res = '0;
      q_ctrl_d = '0; q_rdw = '0;
      model_reset();

      #3;
      chk("reset valid_e", 64'(valid_e), 64'(0));
      chk("reset ctrl_e",  64'(ctrl_e),  64'(0));
      chk("reset pc4_e",   64'(pc4_e),   64'(0));
      chk("reset rd_e",    64'(rd_e),    64'(0));
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 10; i++) begin
         regwrite_w = tv[i].rw; rd_w = tv[i].rdw; result_w = tv[i].res;
         valid_d = tv[i].vd; ld_d = tv[i].ld; ctrl_d = tv[i].ctrl;
         instr_d = mk(tv[i].rd, tv[i].rs1, tv[i].rs2, 3'(i));
         pc_d = 32'h1000 + 32'(4 * i); pc4_d = pc_d + 32'd4; imm_d = 32'(i) << 8;
         stall_e = tv[i].st; flush_e = tv[i].fl;
         #2;
         chk($sformatf("vec%0d stall_d", i), 64'(stall_d), 64'(tv[i].x_stall));
         step_model();
         chk($sformatf("vec%0d valid_e", i), 64'(valid_e), 64'(tv[i].x_valid));
         chk($sformatf("vec%0d ctrl_e", i), 64'(ctrl_e), 64'(tv[i].x_ctrl));
         if (tv[i].x_data) begin
            chk($sformatf("vec%0d rd1_e", i), 64'(rd1_e), 64'(tv[i].x_rd1));
            chk($sformatf("vec%0d rd2_e", i), 64'(rd2_e), 64'(tv[i].x_rd2));
         end
      end

      // Mid-stream reset, with a write-back attempted while reset is held.
      idle();
      regwrite_w = 1; rd_w = 5'd10; result_w = 32'h55;
      valid_d = 1; ld_d = 1; instr_d = mk(5'd8, 5'd5, 5'd7, 3'd6);
      ctrl_d = 24'hABCDEF; pc_d = 32'hCAFE0000; pc4_d = 32'hCAFE0004; imm_d = 32'h1;
      cycle();
      rst = 1'b0;
      #1;
      chk("async valid_e", 64'(valid_e), 64'(0));
      chk("async ld_e",    64'(ld_e),    64'(0));
      chk("async ctrl_e",  64'(ctrl_e),  64'(0));
      chk("async rd1_e",   64'(rd1_e),   64'(0));
      chk("async pc_e",    64'(pc_e),    64'(0));
      chk("async rd_e",    64'(rd_e),    64'(0));
      model_reset();
      result_w = 32'h99;
      @(posedge clk);
      #1;
      chk("rst hold valid_e", 64'(valid_e), 64'(0));
      chk("rst hold imm_e",   64'(imm_e),   64'(0));
      rst = 1'b1;
      regwrite_w = 0;
      instr_d = mk(5'd1, 5'd10, 5'd10, 3'd0);
      cycle();
      chk("x10 after reset rd1_e", 64'(rd1_e), 64'(0));
      chk("x10 after reset valid_e", 64'(valid_e), 64'(1));

      for (int i = 0; i < 3000; i++) begin
         int unsigned span;
         span = (i % 4 == 0) ? 31 : 7;
         regwrite_w = ($urandom_range(0, 1) == 1);
         rd_w       = 5'($urandom_range(0, span));
         result_w   = $urandom;
         valid_d    = ($urandom_range(0, 9) != 0);
         ld_d       = ($urandom_range(0, 2) == 0);
         instr_d    = mk(5'($urandom_range(0, span)), 5'($urandom_range(0, span)),
                         5'($urandom_range(0, span)), 3'($urandom));
         instr_d[31:25] = 7'($urandom);
         ctrl_d     = 24'($urandom);
         imm_d      = $urandom;
         pc_d       = $urandom;
         pc4_d      = pc_d + 32'd4;
         stall_e    = ($urandom_range(0, 4) == 0);
         flush_e    = ($urandom_range(0, 9) == 0);
         cycle();
      end
      idle();

      // 64-bit / 16-register instance: wide values and 4-bit register indices.
      q_rw = 1; q_rdw = 4'd3; q_res = 64'hFFFF_0000_0000_0001;
      q_valid_d = 1; q_instr_d = mk(5'h13, 5'h03, 5'h00, 3'd5);
      q_imm_d = 64'hFFFF_0000_0000_0001; q_pc_d = 64'hFFFF_0000_0000_0001;
      q_pc4_d = 64'hFFFF_0000_0000_0005; q_ctrl_d = 24'h123456;
      @(posedge clk);
      #1;
      chk("w64 bypass rd1_e", q_rd1_e, 64'hFFFF_0000_0000_0001);
      chk("w64 imm_e",        q_imm_e, 64'hFFFF_0000_0000_0001);
      chk("w64 pc4_e",        q_pc4_e, 64'hFFFF_0000_0000_0005);
      chk("w64 rd_e",         64'(q_rd_e), 64'h3);
      chk("w64 funct3_e",     64'(q_f3_e), 64'h5);
      chk("w64 valid_e",      64'(q_valid_e), 64'h1);
      q_rw = 0; q_res = '0;
      q_instr_d = mk(5'h02, 5'h13, 5'h03, 3'd1);
      @(posedge clk);
      #1;
      chk("w64 stored rd2_e",  q_rd2_e, 64'hFFFF_0000_0000_0001);
      chk("w64 alias rd1_e",   q_rd1_e, 64'hFFFF_0000_0000_0001);
      chk("w64 rs1_e",         64'(q_rs1_e), 64'h3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
